// File: rtl/ipm_distributed_fifo_v1_3_if.sv
// rtl/ipm_distributed_fifo_v1_3_if.sv - handshake bundle for the distributed FWFT FIFO
// Purpose: groups the write side, read side, flags and counts of the FIFO.
// Ports:   master modport drives wr_en/wr_data/rd_en and observes the rest;
//          slave modport is the FIFO side.
interface ipm_distributed_fifo_v1_3_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  almost_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   data_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, almost_full, rd_data, empty, almost_empty, data_count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, almost_full, rd_data, empty, almost_empty, data_count, overflow, underflow
  );
endinterface

// File: rtl/ipm_distributed_fifo_v1_3.sv
// rtl/ipm_distributed_fifo_v1_3.sv - single-clock first-word-fall-through FIFO on distributed RAM
// Purpose: shallow elastic buffer; RAM read is combinational, optional one-entry
//          registered prefetch stage (OUT_REG=1) adds one entry of capacity.
// Ports:   clk  - rising-edge clock
//          rst  - asynchronous active-high reset
//          fifo - slave modport: wr_en/wr_data/full/almost_full, rd_en/rd_data/
//                 empty/almost_empty, data_count, overflow/underflow pulses
// Option:  IPM_DFIFO_ERR_FLAG_EN enables registered overflow/underflow pulses;
//          otherwise both are tied low.
module ipm_distributed_fifo_v1_3 #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_REG    = 0,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH-2,
  parameter int AE_LEVEL   = 2
) (
  input logic                      clk,
  input logic                      rst,
  ipm_distributed_fifo_v1_3_if.slave fifo
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
  logic [ADDR_WIDTH:0]   data_count_q, data_count_d;
  logic                  full, empty, wr_acc, rd_acc, ram_pop;
  logic [DATA_WIDTH-1:0] ram_head;

  assign ram_head = mem[rd_ptr_q];

  always_comb begin
    full         = (ram_count_q == DEPTH_C);
    wr_acc       = fifo.wr_en & ~full;
    rd_acc       = fifo.rd_en & ~empty;
    wr_ptr_d     = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, wr_acc};
    rd_ptr_d     = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, ram_pop};
    ram_count_d  = ram_count_q + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, ram_pop};
    // Total occupancy moves with the externally visible handshakes only.
    data_count_d = data_count_q + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};
  end

  // Distributed RAM: no reset on the array so it maps onto select_ram.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= fifo.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_count_q  <= '0;
      data_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_count_q  <= ram_count_d;
      data_count_q <= data_count_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_prefetch
      logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
      logic                  out_vld_q, out_vld_d;

      // Refill the stage whenever it is free or being drained this cycle.
      assign ram_pop = (ram_count_q != '0) & (~out_vld_q | rd_acc);
      assign empty   = ~out_vld_q;

      always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        if (ram_pop) begin
          out_vld_d  = 1'b1;
          out_data_d = ram_head;
        end else if (rd_acc) begin
          out_vld_d  = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_data_q <= '0;
          out_vld_q  <= 1'b0;
        end else begin
          out_data_q <= out_data_d;
          out_vld_q  <= out_vld_d;
        end
      end

      assign fifo.rd_data = out_data_q;
    end else begin : g_comb_read
      assign ram_pop      = rd_acc;
      assign empty        = (ram_count_q == '0);
      assign fifo.rd_data = ram_head;
    end
  endgenerate

  assign fifo.full         = full;
  assign fifo.almost_full  = (ram_count_q >= AF_C);
  assign fifo.empty        = empty;
  assign fifo.almost_empty = (data_count_q <= AE_C);
  assign fifo.data_count   = data_count_q;

`ifdef IPM_DFIFO_ERR_FLAG_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;

  always_comb begin
    overflow_d  = fifo.wr_en & full;
    underflow_d = fifo.rd_en & empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign fifo.overflow  = overflow_q;
  assign fifo.underflow = underflow_q;
`else
  assign fifo.overflow  = 1'b0;
  assign fifo.underflow = 1'b0;
`endif
endmodule
